// File: rtl/cpu_bus_pkg.sv
// rtl/cpu_bus_pkg.sv - shared source ids, access sizes and arbiter state encodings
package cpu_bus_pkg;

    localparam logic SRC_INST = 1'b0;
    localparam logic SRC_DATA = 1'b1;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_t;

endpackage

// File: rtl/arb_src_fifo.sv
// rtl/arb_src_fifo.sv - 1-bit sync FIFO remembering which source issued each in-flight access
module arb_src_fifo #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_push,
    input  logic i_push_src,
    input  logic i_pop,
    output logic o_head,
    output logic o_full,
    output logic o_empty
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic             r_slot [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_head    = r_slot[r_rd_ptr];
    // A pop in the same cycle frees the slot; a pop on empty is dropped so count never underflows.
    assign w_do_push = i_push & (~o_full | i_pop);
    assign w_do_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_slot[r_wr_ptr] <= i_push_src;
    end

endmodule

// File: rtl/sram_bus_arbiter.sv
// rtl/sram_bus_arbiter.sv - fetch vs load/store arbiter for one SRAM-like port with in-order return routing
// Define ARB_RR_EN for round-robin on contention; default is fixed priority with data over inst.
module sram_bus_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_OUTST = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [3:0]        data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [1:0]        mem_size,
    output logic [3:0]        mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t r_state;
    logic       r_lock_src;
    logic       w_pick;
    logic       w_sel;
    logic       w_locked;
    logic       w_push;
    logic       w_pop;
    logic       w_head;
    logic       w_full;
    logic       w_empty;

`ifdef ARB_RR_EN
    logic r_last_grant;

    always_comb begin
        w_pick = data_req ? SRC_DATA : SRC_INST;
        if (inst_req && data_req) w_pick = ~r_last_grant;
    end

    always_ff @(posedge clk) begin
        if (rst)         r_last_grant <= SRC_INST;
        else if (w_push) r_last_grant <= w_sel;
    end
`else
    assign w_pick = data_req ? SRC_DATA : SRC_INST;
`endif

    assign w_locked = (r_state == ST_LOCK);
    assign w_sel    = w_locked ? r_lock_src : w_pick;
    // Entering LOCK already required a free slot, and the count cannot grow while locked.
    assign mem_req  = w_locked | (~w_full & (inst_req | data_req));
    assign w_push   = mem_req & mem_addr_ok;
    assign w_pop    = mem_data_ok & ~w_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_lock_src <= SRC_INST;
        end else begin
            case (r_state)
                ST_IDLE: if (mem_req && !mem_addr_ok) begin
                    r_state    <= ST_LOCK;
                    r_lock_src <= w_sel;
                end
                ST_LOCK: if (mem_addr_ok) r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_wr    = 1'b0;
        mem_size  = SIZE_W;
        mem_wstrb = 4'h0;
        mem_addr  = inst_addr;
        mem_wdata = '0;
        if (w_sel == SRC_DATA) begin
            mem_wr    = data_wr;
            mem_size  = data_size;
            mem_wstrb = data_wstrb;
            mem_addr  = data_addr;
            mem_wdata = data_wdata;
        end
    end

    assign inst_addr_ok = w_push & (w_sel == SRC_INST);
    assign data_addr_ok = w_push & (w_sel == SRC_DATA);
    assign inst_data_ok = w_pop & (w_head == SRC_INST);
    assign data_data_ok = w_pop & (w_head == SRC_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    arb_src_fifo #(
        .DEPTH(MAX_OUTST)
    ) u_src_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (w_push),
        .i_push_src(w_sel),
        .i_pop     (w_pop),
        .o_head    (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// tb/tb_sram_bus_arbiter.sv - directed bench for sram_bus_arbiter
module tb_sram_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sram_bus_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .MAX_OUTST(2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .inst_req    (inst_req),
        .inst_addr   (inst_addr),
        .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok),
        .inst_rdata  (inst_rdata),
        .data_req    (data_req),
        .data_wr     (data_wr),
        .data_size   (data_size),
        .data_wstrb  (data_wstrb),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok),
        .data_rdata  (data_rdata),
        .mem_req     (mem_req),
        .mem_wr      (mem_wr),
        .mem_size    (mem_size),
        .mem_wstrb   (mem_wstrb),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_addr_ok (mem_addr_ok),
        .mem_data_ok (mem_data_ok),
        .mem_rdata   (mem_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns after combinational settle, well away from the clock edge.
    task automatic settle();
        #1;
    endtask

    logic exp_data_win [4];

    initial begin
        rst = 1'b1;
        inst_req = 1'b0; inst_addr = '0;
        data_req = 1'b0; data_wr = 1'b0; data_size = 2'd2; data_wstrb = 4'h0;
        data_addr = '0; data_wdata = '0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
`ifdef ARB_RR_EN
        exp_data_win = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_data_win = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        tick(); tick();
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_addr_ok", 64'({inst_addr_ok, data_addr_ok}), 64'd0);
        chk("rst_data_ok", 64'({inst_data_ok, data_data_ok}), 64'd0);
        rst = 1'b0;

        // 1: single fetch, data one cycle later
        inst_req = 1'b1; inst_addr = 32'h1C00_0000; mem_addr_ok = 1'b1;
        settle();
        chk("t1_mem_req", 64'(mem_req), 64'd1);
        chk("t1_inst_addr_ok", 64'(inst_addr_ok), 64'd1);
        chk("t1_mem_addr", 64'(mem_addr), 64'h1C00_0000);
        chk("t1_fetch_drive", 64'({mem_wr, mem_size, mem_wstrb}), 64'({1'b0, 2'd2, 4'h0}));
        tick();
        inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h0280_1C04;
        settle();
        chk("t1_inst_data_ok", 64'({inst_data_ok, data_data_ok}), 64'b10);
        chk("t1_rdata", 64'(inst_rdata), 64'h0280_1C04);
        tick();
        mem_data_ok = 1'b0;

        // 2: contention, data first, returns in issue order
        inst_req = 1'b1; inst_addr = 32'h1C00_0004;
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h0000_0100;
        mem_addr_ok = 1'b1;
        settle();
        chk("t2_first_grant", 64'({data_addr_ok, inst_addr_ok}), 64'b10);
        chk("t2_first_addr", 64'(mem_addr), 64'h0000_0100);
        tick();
        data_req = 1'b0;
        settle();
        chk("t2_second_grant", 64'({data_addr_ok, inst_addr_ok}), 64'b01);
        chk("t2_second_addr", 64'(mem_addr), 64'h1C00_0004);
        tick();
        inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h1111_1111;
        settle();
        chk("t2_ret0", 64'({data_data_ok, inst_data_ok}), 64'b10);
        chk("t2_ret0_rdata", 64'(data_rdata), 64'h1111_1111);
        tick();
        mem_rdata = 32'h2222_2222;
        settle();
        chk("t2_ret1", 64'({data_data_ok, inst_data_ok}), 64'b01);
        tick();
        mem_data_ok = 1'b0;

        // 3: store stalled three cycles, fetch arrives mid-stall
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_wstrb = 4'hF;
        data_addr = 32'h0000_0104; data_wdata = 32'hDEAD_BEEF;
        settle();
        chk("t3_c0_hold", 64'({mem_req, mem_wr, data_addr_ok, mem_addr}), {1'b1, 1'b1, 1'b0, 32'h0000_0104});
        tick();
        inst_req = 1'b1; inst_addr = 32'h1C00_0008;
        settle();
        chk("t3_c1_hold", 64'({mem_req, mem_wr, inst_addr_ok, mem_addr}), {1'b1, 1'b1, 1'b0, 32'h0000_0104});
        tick();
        settle();
        chk("t3_c2_hold", 64'({mem_wstrb, mem_wdata}), {4'hF, 32'hDEAD_BEEF});
        chk("t3_c2_addr", 64'(mem_addr), 64'h0000_0104);
        tick();
        mem_addr_ok = 1'b1;
        settle();
        chk("t3_store_accept", 64'({data_addr_ok, inst_addr_ok}), 64'b10);
        tick();
        data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'h0;
        settle();
        chk("t3_inst_accept", 64'({data_addr_ok, inst_addr_ok}), 64'b01);
        chk("t3_inst_addr", 64'(mem_addr), 64'h1C00_0008);
        tick();
        inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
        settle();
        chk("t3_ret0", 64'({data_data_ok, inst_data_ok}), 64'b10);
        tick();
        chk("t3_ret1", 64'({data_data_ok, inst_data_ok}), 64'b01);
        tick();
        mem_data_ok = 1'b0;

        // 4: two outstanding fetches fill the FIFO
        inst_req = 1'b1; inst_addr = 32'h1C00_0010; mem_addr_ok = 1'b1;
        settle();
        chk("t4_acc0", 64'(inst_addr_ok), 64'd1);
        tick();
        inst_addr = 32'h1C00_0014;
        settle();
        chk("t4_acc1", 64'(inst_addr_ok), 64'd1);
        tick();
        inst_addr = 32'h1C00_0018;
        settle();
        chk("t4_full_block", 64'({mem_req, inst_addr_ok}), 64'b00);
        tick();
        mem_data_ok = 1'b1; mem_rdata = 32'h0000_000A;
        settle();
        chk("t4_pop_same_cycle", 64'({inst_data_ok, mem_req, inst_addr_ok}), 64'b100);
        tick();
        mem_data_ok = 1'b0;
        settle();
        chk("t4_regrant", 64'({mem_req, inst_addr_ok}), 64'b11);
        chk("t4_regrant_addr", 64'(mem_addr), 64'h1C00_0018);
        tick();
        inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
        settle();
        chk("t4_drain0", 64'(inst_data_ok), 64'd1);
        tick();
        chk("t4_drain1", 64'(inst_data_ok), 64'd1);
        tick();
        chk("t4_spurious0", 64'({inst_data_ok, data_data_ok}), 64'b00);
        tick();
        chk("t4_spurious1", 64'({inst_data_ok, data_data_ok}), 64'b00);
        tick();
        mem_data_ok = 1'b0;

        // 5: reset while locked with one access in flight
        inst_req = 1'b1; inst_addr = 32'h1C00_0020; mem_addr_ok = 1'b1;
        tick();
        inst_req = 1'b0; data_req = 1'b1; data_addr = 32'h0000_0200; mem_addr_ok = 1'b0;
        settle();
        chk("t5_lock_req", 64'({mem_req, data_addr_ok}), 64'b10);
        tick();
        rst = 1'b1; data_req = 1'b0;
        tick();
        rst = 1'b0; mem_data_ok = 1'b1;
        settle();
        chk("t5_after_rst_req", 64'(mem_req), 64'd0);
        chk("t5_after_rst_ok", 64'({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}), 64'd0);
        tick();
        mem_data_ok = 1'b0; inst_req = 1'b1; inst_addr = 32'h1C00_0024; mem_addr_ok = 1'b1;
        settle();
        chk("t5_new_grant", 64'({inst_addr_ok, data_addr_ok}), 64'b10);
        chk("t5_new_addr", 64'(mem_addr), 64'h1C00_0024);
        tick();
        inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
        settle();
        chk("t5_new_ret", 64'(inst_data_ok), 64'd1);
        tick();
        mem_data_ok = 1'b0;

        // 6: continuous contention
        inst_req = 1'b1; inst_addr = 32'h1C00_0030;
        data_req = 1'b1; data_addr = 32'h0000_0300; mem_addr_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk($sformatf("t6_grant%0d", i), 64'({data_addr_ok, inst_addr_ok}),
                exp_data_win[i] ? 64'b10 : 64'b01);
            tick();
            mem_data_ok = 1'b1;
        end
        inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0;
        tick();
        mem_data_ok = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
